// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-domain clock-gating controller.
// Each domain independently runs ON -> IDLE -> OFF -> WAKE -> ON. The
// enable for the domain's ICG is a flop, so it only changes on clk_i
// rising edges. Status and wake acknowledge are derived per domain.
// Domains share nothing but the clock, reset and force_on_i.
module clk_gate_ctrl #(
  parameter int NUM_DOM  = 4,   // number of gated domains, 1..32
  parameter int IDLE_CYC = 16,  // idle cycles before gating, 1..65535
  parameter int WAKE_CYC = 2    // settle cycles after ungating, 1..255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_DOM-1:0] busy_i,
  input  logic [NUM_DOM-1:0] wake_req_i,
  input  logic               force_on_i,
  output logic [NUM_DOM-1:0] en_o,
  output logic [NUM_DOM-1:0] wake_ack_o,
  output logic [NUM_DOM-1:0] gated_o
);

  // Counter reload values. IDLE counts the remaining idle samples before
  // gating; WAKE counts the remaining settle edges before the domain is ON.
  localparam logic [15:0] IDLE_LOAD = 16'(IDLE_CYC - 1);
  localparam logic [15:0] WAKE_LOAD = 16'(WAKE_CYC - 1);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } state_t;

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        en_q, gated_q;
    logic        keep;

    // Anything that wants this domain clocked keeps it out of the idle path.
    assign keep = busy_i[g] | wake_req_i[g] | force_on_i;

    // Next-state and counter decode for this domain.
    always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_ON: begin
          if (!keep) begin
            state_d = ST_IDLE;
            cnt_d   = IDLE_LOAD;
          end
        end
        ST_IDLE: begin
          // keep wins over expiry: a request on the last idle edge returns to ON.
          if (keep) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = ST_OFF;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_OFF: begin
          if (keep) begin
            state_d = ST_WAKE;
            cnt_d   = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          // Wake cannot be aborted; keep is ignored until the settle time ends.
          if (cnt_q == '0) begin
            state_d = ST_ON;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      endcase
    end

    // State, counter and registered outputs; reset forces the domain ON.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_ON;
        cnt_q   <= '0;
        en_q    <= 1'b1;
        gated_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        state_q <= state_d;
        cnt_q   <= cnt_d;
        en_q    <= (state_d != ST_OFF);
        gated_q <= (state_d == ST_OFF);
      end
    end

    assign en_o[g]       = en_q;
    assign gated_o[g]    = gated_q;
    // Ack only once the clock is settled (ON or IDLE); follows the request down.
    assign wake_ack_o[g] = wake_req_i[g] & ((state_q == ST_ON) | (state_q == ST_IDLE));
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios followed by
// randomized traffic, all compared against a counting reference model.
module tb_clk_gate_ctrl;

  localparam int NUM_DOM  = 4;
  localparam int IDLE_CYC = 4;
  localparam int WAKE_CYC = 2;
  localparam logic [NUM_DOM-1:0] ALL1 = '1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_DOM-1:0] busy;
  logic [NUM_DOM-1:0] wake_req;
  logic               force_on;
  logic [NUM_DOM-1:0] en;
  logic [NUM_DOM-1:0] wake_ack;
  logic [NUM_DOM-1:0] gated;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a domain is either gated, settling (edges left before
  // it is usable), or running with a count of consecutive idle samples.
  bit m_gated     [NUM_DOM];
  int m_wake_left [NUM_DOM];
  int m_streak    [NUM_DOM];

  clk_gate_ctrl #(
    .NUM_DOM  (NUM_DOM),
    .IDLE_CYC (IDLE_CYC),
    .WAKE_CYC (WAKE_CYC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .busy_i     (busy),
    .wake_req_i (wake_req),
    .force_on_i (force_on),
    .en_o       (en),
    .wake_ack_o (wake_ack),
    .gated_o    (gated)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NUM_DOM; i++) begin
      m_gated[i]     = 1'b0;
      m_wake_left[i] = 0;
      m_streak[i]    = 0;
    end
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < NUM_DOM; i++) begin
      bit keep;
      keep = busy[i] | wake_req[i] | force_on;
      if (m_gated[i]) begin
        if (keep) begin
          m_gated[i]     = 1'b0;
          m_wake_left[i] = WAKE_CYC;
          m_streak[i]    = 0;
        end
      end else if (m_wake_left[i] > 0) begin
        m_wake_left[i]--;
      end else if (keep) begin
        m_streak[i] = 0;
      end else begin
        m_streak[i]++;
        if (m_streak[i] == IDLE_CYC + 1) begin
          m_gated[i]  = 1'b1;
          m_streak[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [NUM_DOM-1:0] exp_en();
    logic [NUM_DOM-1:0] v;
    for (int i = 0; i < NUM_DOM; i++) v[i] = !m_gated[i];
    return v;
  endfunction

  function automatic logic [NUM_DOM-1:0] exp_gated();
    logic [NUM_DOM-1:0] v;
    for (int i = 0; i < NUM_DOM; i++) v[i] = m_gated[i];
    return v;
  endfunction

  function automatic logic [NUM_DOM-1:0] exp_ack();
    logic [NUM_DOM-1:0] v;
    for (int i = 0; i < NUM_DOM; i++)
      v[i] = wake_req[i] & !m_gated[i] & (m_wake_left[i] == 0);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".en"},    32'(en),       32'(exp_en()));
    check({tag, ".gated"}, 32'(gated),    32'(exp_gated()));
    check({tag, ".ack"},   32'(wake_ack), 32'(exp_ack()));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    // Reset state, with a request pattern visible through the ack path.
    rst      = 1'b1;
    busy     = '0;
    force_on = 1'b0;
    wake_req = 4'b1010;
    model_reset();
    #3;
    check("rst_en",    32'(en),       32'(ALL1));
    check("rst_gated", 32'(gated),    32'h0);
    check("rst_ack",   32'(wake_ack), 32'h0000_000a);
    @(negedge clk);
    @(negedge clk);
    check_all("rst_hold");
    wake_req = '0;
    busy     = '1;
    rst      = 1'b0;
    tick("post_rst");

    // Idle gating of domain 0 while the others stay busy.
    busy = 4'b1110;
    for (int k = 1; k <= IDLE_CYC; k++) begin
      tick("idle_gate");
      check("idle_en0_hold", 32'(en[0]), 32'h1);
    end
    tick("idle_gate_exp");
    check("idle_en0_fall", 32'(en[0]),    32'h0);
    check("idle_gated0",   32'(gated[0]), 32'h1);
    check("idle_others",   32'(en[3:1]),  32'h7);

    // Wake handshake on domain 1 from OFF.
    busy = 4'b1100;
    for (int k = 0; k <= IDLE_CYC; k++) tick("d1_gate");
    check("d1_gated", 32'(gated[1]), 32'h1);
    wake_req = 4'b0010;
    tick("wake_w1");
    check("wake_en1_w1",  32'(en[1]),       32'h1);
    check("wake_ack1_w1", 32'(wake_ack[1]), 32'h0);
    tick("wake_w2");
    check("wake_ack1_w2", 32'(wake_ack[1]), 32'h0);
    tick("wake_w3");
    check("wake_ack1_w3", 32'(wake_ack[1]), 32'h1);
    wake_req = '0;
    #1;
    check("wake_ack1_drop", 32'(wake_ack[1]), 32'h0);

    // Abort near expiry: keep sampled 1 on the edge the idle count would end.
    busy = '1;
    for (int k = 0; k <= WAKE_CYC; k++) tick("d0_rewake");
    busy = 4'b1110;
    for (int k = 1; k <= IDLE_CYC; k++) tick("abort_idle");
    busy = '1;
    tick("abort_e5");
    check("abort_en0",    32'(en[0]),    32'h1);
    check("abort_gated0", 32'(gated[0]), 32'h0);
    for (int k = 0; k < IDLE_CYC + 2; k++) begin
      tick("abort_after");
      check("abort_en0_stay", 32'(en[0]), 32'h1);
    end

    // One-cycle force_on while every domain is gated.
    busy = '0;
    for (int k = 0; k <= IDLE_CYC; k++) tick("all_gate");
    check("all_gated", 32'(gated), 32'(ALL1));
    check("all_en_off", 32'(en),   32'h0);
    force_on = 1'b1;
    tick("force_w1");
    force_on = 1'b0;
    check("force_en_all", 32'(en), 32'(ALL1));
    tick("force_w2");
    tick("force_w3");
    check("force_ungated", 32'(gated), 32'h0);
    for (int k = 1; k <= IDLE_CYC; k++) tick("force_idle");
    check("force_en_before", 32'(en), 32'(ALL1));
    tick("force_regate");
    check("force_regated", 32'(gated), 32'(ALL1));

    // WAKE completes even if keep drops immediately.
    busy = 4'b0100;
    tick("noabort_w1");
    busy = '0;
    tick("noabort_w2");
    tick("noabort_w3");
    check("noabort_en2", 32'(en[2]),    32'h1);
    check("noabort_g2",  32'(gated[2]), 32'h0);
    for (int k = 0; k <= IDLE_CYC; k++) tick("noabort_regate");
    check("noabort_regated", 32'(gated[2]), 32'h1);

    // Asynchronous reset while domain 0 is mid-WAKE.
    busy = 4'b0001;
    tick("rstwake_w1");
    busy = '0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rstwake_en",    32'(en),    32'(ALL1));
    check("rstwake_gated", 32'(gated), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= IDLE_CYC; k++) tick("rstwake_idle");
    check("rstwake_en_before", 32'(en), 32'(ALL1));
    tick("rstwake_regate");
    check("rstwake_regated", 32'(gated), 32'(ALL1));

    // Randomized traffic; requesters hold wake_req until acked.
    for (int c = 0; c < 1500; c++) begin
      logic [NUM_DOM-1:0] ack_now;
      ack_now = exp_ack();
      for (int i = 0; i < NUM_DOM; i++) begin
        if ($urandom_range(7) == 0) busy[i] = ~busy[i];
        if (wake_req[i]) begin
          if (ack_now[i] && $urandom_range(1) == 0) wake_req[i] = 1'b0;
        end else if ($urandom_range(15) == 0) begin
          wake_req[i] = 1'b1;
        end
      end
      force_on = ($urandom_range(63) == 0);
      #1;
      check("rand_ack_comb", 32'(wake_ack), 32'(exp_ack()));
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DOM, default 4, giving the number of gated clock domains (legal range 1..32).
REQ-002 The block SHALL have parameter IDLE_CYC, default 16, giving the idle cycles before gating (legal range 1..65535).
REQ-003 The block SHALL have parameter WAKE_CYC, default 2, giving the settle cycles after ungating before ack (legal range 1..255).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port busy_i, input, NUM_DOM bits: per-domain activity; 1 = domain needs clock.
REQ-007 The block SHALL have port wake_req_i, input, NUM_DOM bits: per-domain wake request, held until ack.
REQ-008 The block SHALL have port force_on_i, input, 1 bit: global software override that keeps or brings every domain on.
REQ-009 The block SHALL have port en_o, output, NUM_DOM bits: registered enable for each domain's clk_icg en_i.
REQ-010 The block SHALL have port wake_ack_o, output, NUM_DOM bits: wake acknowledge.
REQ-011 The block SHALL have port gated_o, output, NUM_DOM bits: status; 1 = domain clock is off.

Function
REQ-012 Each domain SHALL run an independent FSM with states ON, IDLE, OFF and WAKE, plus a 16-bit down-counter.
REQ-013 "Keep" for domain i SHALL mean busy_i[i] | wake_req_i[i] | force_on_i.
REQ-014 In ON, the domain SHALL set en=1; if keep=0 it SHALL move to IDLE with cnt=IDLE_CYC-1, otherwise it SHALL stay in ON.
REQ-015 In IDLE, the domain SHALL set en=1; if keep=1 it SHALL move to ON; if keep=0 and cnt==0 it SHALL move to OFF; otherwise it SHALL decrement cnt.
REQ-016 In OFF, the domain SHALL set en=0; if keep=1 it SHALL move to WAKE with cnt=WAKE_CYC-1.
REQ-017 In WAKE, the domain SHALL set en=1; when cnt==0 it SHALL move to ON regardless of keep; otherwise it SHALL decrement cnt.
REQ-018 en_o[i] SHALL be a flop, driven 1 in the cycle the FSM is in ON, IDLE or WAKE and 0 in OFF, so it changes only on clk_i rising edges (glitch-free into the ICG).
REQ-019 Gating latency: en_o[i] SHALL fall on the edge after keep has been sampled 0 on IDLE_CYC+1 consecutive edges.
REQ-020 Wake latency: en_o[i] SHALL rise 1 edge after keep is first sampled 1 in OFF.
REQ-021 After wake, wake_ack_o[i] SHALL first be high WAKE_CYC+1 edges after keep is first sampled 1 in OFF.
REQ-022 wake_ack_o[i] SHALL equal wake_req_i[i] & (state is ON or IDLE), combinationally from the registered state.
REQ-023 wake_ack_o[i] SHALL never be high in OFF or WAKE.
REQ-024 The requester SHALL hold wake_req_i until ack; wake_ack_o SHALL drop in the same cycle wake_req_i drops.
REQ-025 A wake_req_i arriving in ON SHALL be acked in the same cycle.
REQ-026 gated_o[i] SHALL be registered and equal 1 exactly when the state is OFF.
REQ-027 Simultaneous events: keep rising on the same edge IDLE would expire SHALL send the domain to ON, never OFF.
REQ-028 WAKE SHALL be non-abortable: keep dropping during WAKE SHALL still complete to ON and then restart the idle countdown.
REQ-029 force_on_i=1 SHALL hold all domains in ON, or drive them through WAKE to ON.
REQ-030 Domains SHALL NOT interact: no shared counter and no arbitration.

Reset
REQ-031 While rst_i=1, every FSM SHALL be in ON with cnt=0, en_o all 1s, gated_o all 0s, and wake_ack_o = wake_req_i.
REQ-032 Reset assertion SHALL take effect immediately, asynchronously, including mid-IDLE and mid-WAKE.
REQ-033 Deassertion SHALL be synchronized externally; the first post-reset edge SHALL evaluate the ON state.

Verification
REQ-034 Idle gating (IDLE_CYC=4, WAKE_CYC=2): busy_i[0] drops before edge E1, all other keep terms 0 -> en_o[0] falls after E5, gated_o[0]=1 after E5, and other domains are unaffected if they are busy.
REQ-035 Abort near expiry (IDLE_CYC=4): busy drops, then reasserts so it is sampled 1 at E5 -> domain returns to ON, en_o[0] never falls, gated_o stays 0.
REQ-036 Wake handshake from OFF (WAKE_CYC=2): wake_req_i[1] rises before edge W1 -> en_o[1]=1 after W1, wake_ack_o[1]=1 after W3; wake_req drops -> ack drops the same cycle.
REQ-037 force_on_i pulse of 1 cycle while all domains are OFF -> all en_o=1 after the next edge, all domains reach ON after WAKE_CYC+1 edges, then regate after IDLE_CYC+1 further idle edges.
REQ-038 Reset mid-WAKE: rst_i asserted between edges -> en_o all 1s, gated_o 0 and FSM in ON immediately without waiting for an edge; after release the domain regates after IDLE_CYC+1 idle edges.
